dec_scan_ctrl: RTL

- Sequential code generator that drives the 3-bit select input of the 3-to-8 decoder stage (octal codes 0..7).
- Steps the select through the codes with a programmable dwell time, in up, down, single-sweep or hold modes.
- Provides a qualifier and event strobes for downstream logic, e.g. LED/column scanning.

---
 rtl/dec_scan_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dec_scan_ctrl.sv
// Select-code sequencer for the 3-to-8 decoder stage: steps sel through the
// octal codes with a programmable dwell, in up, down, single-sweep or hold mode.
module dec_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               step_pulse,
    output logic               sweep_done,
    output logic               busy,
    output logic               dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE with stop
    // low; stop is level-sensitive, beats start and any dwell expiry, and
    // forces IDLE on the next edge. There is no back-pressure on the outputs.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'o0;
            cnt_q   <= '0;
            mode_q  <= MODE_UP;
            dwell_q <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    sel_d   = (mode == MODE_DOWN) ? 3'o7 : 3'o0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (mode_q != MODE_HOLD) begin
                    if (cnt_q == dwell_q) begin
                        cnt_d = '0;
                        // A single sweep ends on the expiry of code 7 without stepping.
                        if (mode_q == MODE_SWEEP && sel_q == 3'o7) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            step_d = 1'b1;
                            if (mode_q == MODE_DOWN) begin
                                sel_d = sel_q - 3'd1;
                            end else begin
                                sel_d = sel_q + 3'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign sel_valid  = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign step_pulse = step_q;
    assign sweep_done = done_q;
    assign dbg_state  = state_q;

endmodule
